// File: rtl/adc_pkg.sv
// Shared types and constants for the flash ADC conversion sequencer.
// Imported by the controller and its phase timer.
package adc_pkg;

    localparam int CODE_W = 4;
    localparam logic [CODE_W-1:0] CODE_MAX = 4'd15;
    localparam logic [CODE_W-1:0] CODE_MIN = 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        TRACK,
        SETTLE,
        LATCH,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/adc_phase_timer.sv
// Loadable down-counter timing the track and settle phases.
// Holds at zero once expired until reloaded.
module adc_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] val,
    output logic         expire
);

    logic [W-1:0] count;

    // Count down toward zero; abort clears, load takes the phase length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/adc_conv_ctrl.sv
// Conversion sequencer: track/settle/latch/capture per sample,
// averages 2^AVG_LOG2 samples and reports over start/busy/done.
module adc_conv_ctrl
    import adc_pkg::*;
#(
    parameter int TRACK_CYC  = 4,
    parameter int SETTLE_CYC = 2,
    parameter int AVG_LOG2   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       cont,
    input  logic                       abort,
    input  logic [CODE_W-1:0]          code_in,
    output logic                       sh_track,
    output logic                       cmp_en,
    output logic                       cmp_latch,
    output logic                       busy,
    output logic                       done,
    output logic [CODE_W-1:0]          result,
    output logic [CODE_W+AVG_LOG2-1:0] sum,
    output logic                       ovr,
    output logic                       udr
);

    localparam int AW   = CODE_W + AVG_LOG2;
    localparam int CW   = AVG_LOG2 + 1;
    localparam int TMAX = (TRACK_CYC > SETTLE_CYC) ? TRACK_CYC : SETTLE_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);
    localparam logic [TW-1:0] T_LD = TW'(TRACK_CYC - 1);
    localparam logic [TW-1:0] S_LD = TW'(SETTLE_CYC - 1);

    state_t            state;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     acc_nxt;
    logic [CW-1:0]     cnt;
    logic              ovr_w;
    logic              udr_w;
    logic              ovr_nxt;
    logic              udr_nxt;
    logic              last;
    logic              tload;
    logic [TW-1:0]     tval;
    logic              expire;
    logic [CODE_W-1:0] rcode;

    assign acc_nxt = acc + AW'(code_in);
    assign ovr_nxt = ovr_w | (code_in == CODE_MAX);
    assign udr_nxt = udr_w | (code_in == CODE_MIN);
    assign last    = (cnt == LAST);

    // Round half up before the shift; one spare bit keeps the add exact
    if (AVG_LOG2 == 0) begin : g_norm
        assign rcode = acc_nxt[CODE_W-1:0];
    end else begin : g_rnd
        logic [AW:0] rsum;
        logic [AW:0] rq;
        assign rsum  = {1'b0, acc_nxt} + (AW+1)'(1 << (AVG_LOG2 - 1));
        assign rq    = rsum >> AVG_LOG2;
        assign rcode = (rq > (AW+1)'(CODE_MAX)) ? CODE_MAX : rq[CODE_W-1:0];
    end

    // Load the timer on entry to TRACK or SETTLE so phase length is exact
    always_comb begin
        tload = 1'b0;
        tval  = T_LD;
        if (!abort) begin
            unique case (state)
                IDLE:    tload = start;
                TRACK: begin
                    tload = expire;
                    tval  = S_LD;
                end
                CAPTURE: tload = !last;
                DONE:    tload = cont;
                default: tload = 1'b0;
            endcase
        end
    end

    adc_phase_timer #(
        .W(TW)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (abort),
        .load  (tload),
        .val   (tval),
        .expire(expire)
    );

    // Sequencer with outputs registered alongside the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovr_w     <= 1'b0;
            udr_w     <= 1'b0;
            sh_track  <= 1'b0;
            cmp_en    <= 1'b0;
            cmp_latch <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            sum       <= '0;
            ovr       <= 1'b0;
            udr       <= 1'b0;
        end else begin
            cmp_latch <= 1'b0;
            done      <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                sh_track <= 1'b0;
                cmp_en   <= 1'b0;
                busy     <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= TRACK;
                            acc      <= '0;
                            cnt      <= '0;
                            ovr_w    <= 1'b0;
                            udr_w    <= 1'b0;
                            sh_track <= 1'b1;
                            cmp_en   <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                    TRACK: begin
                        if (expire) begin
                            state    <= SETTLE;
                            sh_track <= 1'b0;
                        end
                    end
                    SETTLE: begin
                        if (expire) begin
                            state     <= LATCH;
                            cmp_latch <= 1'b1;
                        end
                    end
                    LATCH: begin
                        state <= CAPTURE;
                    end
                    CAPTURE: begin
                        acc   <= acc_nxt;
                        ovr_w <= ovr_nxt;
                        udr_w <= udr_nxt;
                        cnt   <= cnt + CW'(1);
                        if (last) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= rcode;
                            sum    <= acc_nxt;
                            ovr    <= ovr_nxt;
                            udr    <= udr_nxt;
                        end else begin
                            state    <= TRACK;
                            sh_track <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (cont) begin
                            state    <= TRACK;
                            acc      <= '0;
                            cnt      <= '0;
                            ovr_w    <= 1'b0;
                            udr_w    <= 1'b0;
                            sh_track <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            cmp_en <= 1'b0;
                            busy   <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_conv_ctrl.sv
// Self-checking bench for adc_conv_ctrl at default parameters.
// Expected values come from a sample-list model of the averaging rules.
module tb_adc_conv_ctrl;

    localparam int L      = 2;
    localparam int N      = 1 << L;
    localparam int TRK    = 4;
    localparam int P      = TRK + 2 + 2;
    localparam int DONE_C = N * P + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       cont;
    logic       abort;
    logic [3:0] code_in;
    logic       sh_track;
    logic       cmp_en;
    logic       cmp_latch;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic [5:0] sum;
    logic       ovr;
    logic       udr;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] codes[N];
    int         exp_res = 0;
    int         exp_sum = 0;
    int         exp_ovr = 0;
    int         exp_udr = 0;

    always #5 clk = ~clk;

    adc_conv_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cont     (cont),
        .abort    (abort),
        .code_in  (code_in),
        .sh_track (sh_track),
        .cmp_en   (cmp_en),
        .cmp_latch(cmp_latch),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .sum      (sum),
        .ovr      (ovr),
        .udr      (udr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Average of the sample list, rounded half up, clipped to 15
    task automatic model_commit();
        int s;
        int o;
        int u;
        s = 0;
        o = 0;
        u = 0;
        for (int i = 0; i < N; i++) begin
            s += int'(codes[i]);
            if (codes[i] == 4'd15) o = 1;
            if (codes[i] == 4'd0)  u = 1;
        end
        exp_sum = s;
        exp_res = (s + N / 2) / N;
        if (exp_res > 15) exp_res = 15;
        exp_ovr = o;
        exp_udr = u;
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, " result"}, result, exp_res);
        chk({tag, " sum"}, sum, exp_sum);
        chk({tag, " ovr"}, ovr, exp_ovr);
        chk({tag, " udr"}, udr, exp_udr);
    endtask

    // One single-shot conversion starting in cycle 0
    task automatic run(input string tag, input int abort_at,
                       input int extra_start);
        bit ab;
        int ph;
        for (int c = 0; c <= DONE_C + 1; c++) begin
            ab = (abort_at >= 0) && (c > abort_at);
            ph = c % P;
            if (c >= 1) begin
                chk({tag, " busy"}, busy, !ab && c <= DONE_C);
                chk({tag, " done"}, done, !ab && c == DONE_C);
                chk({tag, " latch"}, cmp_latch,
                    !ab && c < DONE_C && ph == TRK + 3);
                chk({tag, " track"}, sh_track,
                    !ab && c < DONE_C && ph >= 1 && ph <= TRK);
                if (c == DONE_C) begin
                    if (!ab) model_commit();
                    chk_outs(tag);
                end
            end
            start = (c == 0) || (c == extra_start);
            abort = (c == abort_at);
            if (c >= 1 && c < DONE_C)
                code_in = codes[(c - 1) / P];
            else
                code_in = 4'($urandom);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        cont    = 1'b0;
        abort   = 1'b0;
        code_in = 4'd0;
        tick();
        tick();
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst cmp_en", cmp_en, 0);
        chk_outs("rst");
        rst = 1'b0;
        tick();

        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre-rst busy", busy, 1);
        chk("pre-rst track", sh_track, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async busy", busy, 0);
        chk("async track", sh_track, 0);
        chk("async cmp_en", cmp_en, 0);
        chk("async latch", cmp_latch, 0);
        chk("async done", done, 0);
        chk_outs("async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("post-rst busy", busy, 0);
            chk("post-rst done", done, 0);
        end

        codes = '{4'd9, 4'd9, 4'd9, 4'd9};
        run("c9", -1, -1);
        codes = '{4'd7, 4'd8, 4'd8, 4'd8};
        run("round", -1, -1);
        codes = '{4'd15, 4'd15, 4'd15, 4'd15};
        run("ovr", -1, -1);
        codes = '{4'd0, 4'd1, 4'd0, 4'd1};
        run("udr", -1, -1);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++)
                codes[i] = 4'($urandom_range(0, 15));
            run("rand", -1, -1);
        end

        for (int i = 0; i < N; i++)
            codes[i] = 4'($urandom_range(0, 15));
        run("busy-start", -1, 12);

        for (int i = 0; i < N; i++)
            codes[i] = 4'($urandom_range(0, 15));
        run("abort", 20, -1);
        run("after-abort", -1, -1);

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort-vs-start busy", busy, 0);
        tick();
        chk("abort-vs-start busy2", busy, 0);

        codes = '{4'd5, 4'd5, 4'd5, 4'd5};
        for (int c = 0; c <= 3 * DONE_C + 2; c++) begin
            if (c >= 1) begin
                chk("cont busy", busy, c <= 3 * DONE_C);
                chk("cont done", done, (c % DONE_C) == 0);
                if ((c % DONE_C) == 0) begin
                    model_commit();
                    chk_outs("cont");
                end
            end
            start   = (c == 0);
            cont    = (c <= 2 * DONE_C);
            code_in = 4'd5;
            tick();
        end
        cont = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
